// File: rtl/register_file_pkg.sv
// Shared definitions for the architectural register file and its rename
// (register-status) table.
//   - Widths, the NULL_TAG / ZERO_WORD constants and boolean aliases.
//   - operand_t: value/tag pair handed to the decoder for one source.
//   - resolve_operand(): operand selection with same-cycle commit bypass.
package register_file_pkg;

  localparam int REG_COUNT       = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int WORD_WIDTH      = 32;
  localparam int ROB_TAG_WIDTH   = 4;
  localparam int ROB_CAPACITY    = 15;

  typedef logic [WORD_WIDTH-1:0]      word_t;
  typedef logic [REG_INDEX_WIDTH-1:0] reg_idx_t;
  typedef logic [ROB_TAG_WIDTH-1:0]   rob_tag_t;

  localparam rob_tag_t NULL_TAG  = {ROB_TAG_WIDTH{1'b0}};
  localparam word_t    ZERO_WORD = {WORD_WIDTH{1'b0}};
  localparam reg_idx_t ZERO_REG  = {REG_INDEX_WIDTH{1'b0}};
  localparam logic     TRUE      = 1'b1;
  localparam logic     FALSE     = 1'b0;

  typedef struct packed {
    word_t    value;
    rob_tag_t tag;
  } operand_t;

  // A committing producer whose tag still owns the register hands its data
  // straight to the reader, so the decoder never waits an extra cycle.
  function automatic operand_t resolve_operand(
    input reg_idx_t idx,
    input rob_tag_t status_tag,
    input word_t    array_value,
    input logic     commit_valid,
    input rob_tag_t commit_tag,
    input word_t    commit_data,
    input reg_idx_t commit_target
  );
    operand_t op;
    op.value = ZERO_WORD;
    op.tag   = NULL_TAG;
    if (idx == ZERO_REG) begin
      op.value = ZERO_WORD;
      op.tag   = NULL_TAG;
    end else if (commit_valid && (commit_target == idx) && (status_tag == commit_tag)) begin
      op.value = commit_data;
      op.tag   = NULL_TAG;
    end else if (status_tag != NULL_TAG) begin
      op.value = ZERO_WORD;
      op.tag   = status_tag;
    end else begin
      op.value = array_value;
      op.tag   = NULL_TAG;
    end
    return op;
  endfunction

endpackage

// File: rtl/register_file_reg_status_table.sv
// Register-status (rename) table: one ROB tag per architectural register.
// Ports:
//   clk, rst                         clock, async active-low reset
//   rs1_idx/rs2_idx -> rs1_tag/rs2_tag   combinational tag lookups
//   rename_valid, rename_rd, rename_tag  dispatch rename request
//   commit_valid, commit_tag, commit_target  commit clears a matching tag
//   flush                            drop every outstanding rename
module register_file_reg_status_table
  import register_file_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  output rob_tag_t rs1_tag,
  output rob_tag_t rs2_tag,
  input  logic     rename_valid,
  input  reg_idx_t rename_rd,
  input  rob_tag_t rename_tag,
  input  logic     commit_valid,
  input  rob_tag_t commit_tag,
  input  reg_idx_t commit_target,
  input  logic     flush
);

  rob_tag_t status_r [REG_COUNT];

  // Tag state: flush beats rename, rename beats the commit clear, and a
  // commit only clears when its tag still owns the register (a younger
  // rename must survive an older commit). Entry 0 is pinned to NULL_TAG.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        status_r[i] <= NULL_TAG;
      end
    end else begin
      status_r[0] <= NULL_TAG;
      for (int i = 1; i < REG_COUNT; i++) begin
        if (flush) begin
          status_r[i] <= NULL_TAG;
        end else if (rename_valid && (rename_rd == REG_INDEX_WIDTH'(i)) &&
                     (rename_tag != NULL_TAG)) begin
          status_r[i] <= rename_tag;
        end else if (commit_valid && (commit_target == REG_INDEX_WIDTH'(i)) &&
                     (status_r[i] == commit_tag)) begin
          status_r[i] <= NULL_TAG;
        end else begin
          status_r[i] <= status_r[i];
        end
      end
    end
  end

  // Combinational tag lookups for both decoder sources.
  always_comb begin
    rs1_tag = status_r[rs1_idx];
    rs2_tag = status_r[rs2_idx];
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename table and commit bypass.
// Ports:
//   clk, rst                       clock, async active-low reset
//   dec_rs1_in/dec_rs2_in          decoder source indices
//   dec_Vj_out/dec_Qj_out          rs1 value / producer tag (tag 0 = ready)
//   dec_Vk_out/dec_Qk_out          rs2 value / producer tag (tag 0 = ready)
//   dec_rename_signal_in, dec_rd_in, dis_tag_in   dispatch rename
//   rob_commit_signal_in, rob_commit_tag_in,
//   rob_commit_data_in, rob_commit_target_in      ROB commit write
//   rob_flush_in                   discard all renames
module register_file
  import register_file_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs1_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs2_in,
  output logic [WORD_WIDTH-1:0]      dec_Vj_out,
  output logic [WORD_WIDTH-1:0]      dec_Vk_out,
  output logic [ROB_TAG_WIDTH-1:0]   dec_Qj_out,
  output logic [ROB_TAG_WIDTH-1:0]   dec_Qk_out,
  input  logic                       dec_rename_signal_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rd_in,
  input  logic [ROB_TAG_WIDTH-1:0]   dis_tag_in,
  input  logic                       rob_commit_signal_in,
  input  logic [ROB_TAG_WIDTH-1:0]   rob_commit_tag_in,
  input  logic [WORD_WIDTH-1:0]      rob_commit_data_in,
  input  logic [REG_INDEX_WIDTH-1:0] rob_commit_target_in,
  input  logic                       rob_flush_in
);

  word_t    value_r [REG_COUNT];
  rob_tag_t rs1_tag_s;
  rob_tag_t rs2_tag_s;
  operand_t op_j_s;
  operand_t op_k_s;

  register_file_reg_status_table u_status (
    .clk           (clk),
    .rst           (rst),
    .rs1_idx       (dec_rs1_in),
    .rs2_idx       (dec_rs2_in),
    .rs1_tag       (rs1_tag_s),
    .rs2_tag       (rs2_tag_s),
    .rename_valid  (dec_rename_signal_in),
    .rename_rd     (dec_rd_in),
    .rename_tag    (dis_tag_in),
    .commit_valid  (rob_commit_signal_in),
    .commit_tag    (rob_commit_tag_in),
    .commit_target (rob_commit_target_in),
    .flush         (rob_flush_in)
  );

  // Committed values are architectural: written regardless of rename/flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_r[i] <= ZERO_WORD;
      end
    end else begin
      value_r[0] <= ZERO_WORD;
      for (int i = 1; i < REG_COUNT; i++) begin
        if (rob_commit_signal_in && (rob_commit_target_in == REG_INDEX_WIDTH'(i))) begin
          value_r[i] <= rob_commit_data_in;
        end else begin
          value_r[i] <= value_r[i];
        end
      end
    end
  end

  // Operand selection for both sources, including commit bypass.
  always_comb begin
    op_j_s = resolve_operand(dec_rs1_in, rs1_tag_s, value_r[dec_rs1_in],
                             rob_commit_signal_in, rob_commit_tag_in,
                             rob_commit_data_in, rob_commit_target_in);
    op_k_s = resolve_operand(dec_rs2_in, rs2_tag_s, value_r[dec_rs2_in],
                             rob_commit_signal_in, rob_commit_tag_in,
                             rob_commit_data_in, rob_commit_target_in);
    dec_Vj_out = op_j_s.value;
    dec_Qj_out = op_j_s.tag;
    dec_Vk_out = op_k_s.value;
    dec_Qk_out = op_k_s.tag;
  end

endmodule
